jk_seq_driver: RTL and testbench

Drives the J/K inputs of an external jk_flipflop so that its Q output follows a requested bit sequence. The block computes the J/K excitation from the current Q feedback and each target bit, then checks that the flop actually reached the target. It is the driving and checking end of the J/K interface; the flop is the responding end. The block sits next to jk_flipflop instances in self-checking designs and in hardware bring-up.

---
 rtl/jk_seq_driver.sv | 100 ++++++++++
 tb/tb_jk_seq_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_seq_driver.sv
// Drives J/K of an external JK flop so Q follows a target bit stream, then checks Q (JK_SEQ_TOGGLE_EN: toggle excitation).
// Latency: J/K registered at the accept edge, Q checked 2 cycles later; one bit every 3 cycles.
// Backpressure: tgt_ready is low in DRIVE and CHECK; tgt_valid is ignored while busy.
module jk_seq_driver #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_fb,
  output logic             J,
  output logic             K,
  output logic             exp_q,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  input  logic             err_clr
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             mismatch;
  logic             j_nxt, k_nxt;
  logic [CNT_W-1:0] err_base;
  logic [CNT_W-1:0] err_cnt_nxt;

  always_comb begin
    state_nxt = state;
    tgt_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    mismatch  = 1'b0;
    case (state)
      IDLE: begin
        tgt_ready = 1'b1;
        accept    = tgt_valid;
        if (tgt_valid) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy      = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        mismatch  = (q_fb != exp_q);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Excitation needed to move the flop from q_fb to tgt_bit; equal values hold.
  always_comb begin
`ifdef JK_SEQ_TOGGLE_EN
    j_nxt = q_fb ^ tgt_bit;
    k_nxt = q_fb ^ tgt_bit;
`else
    j_nxt = ~q_fb & tgt_bit;
    k_nxt = q_fb & ~tgt_bit;
`endif
  end

  // A clear on the same edge as a mismatch clears first, then counts.
  always_comb begin
    err_base    = err_clr ? '0 : err_cnt;
    err_cnt_nxt = err_base;
    if (mismatch && (err_base != '1)) err_cnt_nxt = err_base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      J        <= 1'b0;
      K        <= 1'b0;
      exp_q    <= 1'b0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_cnt  <= err_cnt_nxt;
      err_flag <= (err_flag & ~err_clr) | mismatch;
      if (accept) begin
        J       <= j_nxt;
        K       <= k_nxt;
        exp_q   <= tgt_bit;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        J <= 1'b0;
        K <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: JK flop model on the feedback path, transaction-level reference model, directed scenarios.
module tb_jk_seq_driver;

  localparam int W = 8;
  localparam int MAXE = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, tgt_valid = 1'b0, tgt_bit = 1'b0, err_clr = 1'b0, stuck = 1'b0;
  logic flop_q, q_fb;
  logic tgt_ready, J, K, exp_q, busy, err_flag;
  logic [W-1:0] bit_cnt, err_cnt;

  logic s_valid = 1'b0;
  logic s_ready, s_j, s_k, s_exp, s_busy, s_flag;
  logic [1:0] s_bits, s_errs;

  int checks = 0;
  int errors = 0;

  jk_seq_driver #(.CNT_W(W)) u_dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(tgt_ready),
    .q_fb(q_fb), .J(J), .K(K), .exp_q(exp_q), .busy(busy), .bit_cnt(bit_cnt),
    .err_cnt(err_cnt), .err_flag(err_flag), .err_clr(err_clr)
  );

  jk_seq_driver #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .tgt_valid(s_valid), .tgt_bit(1'b1), .tgt_ready(s_ready),
    .q_fb(1'b0), .J(s_j), .K(s_k), .exp_q(s_exp), .busy(s_busy), .bit_cnt(s_bits),
    .err_cnt(s_errs), .err_flag(s_flag), .err_clr(1'b0)
  );

  // Driven JK flop; q_fb can be forced low to emulate a broken flop
  assign q_fb = stuck ? 1'b0 : flop_q;
  always @(posedge clk) begin
    if (rst) flop_q <= 1'b0;
    else case ({J, K})
      2'b10:   flop_q <= 1'b1;
      2'b01:   flop_q <= 1'b0;
      2'b11:   flop_q <= ~flop_q;
      default: flop_q <= flop_q;
    endcase
  end

  // Reference: hold when already at target, otherwise set/reset (or toggle)
  function automatic logic [1:0] exc(input logic q, input logic t);
    if (q == t) return 2'b00;
`ifdef JK_SEQ_TOGGLE_EN
    return 2'b11;
`else
    return t ? 2'b10 : 2'b01;
`endif
  endfunction

  int   m_left = 0;
  int   m_bits = 0, m_errs = 0;
  logic m_j = 1'b0, m_k = 1'b0, m_exp = 1'b0, m_flag = 1'b0, m_valid = 1'b0;

  always @(posedge clk) begin : model
    int   e;
    logic f;
    if (rst) begin
      m_left <= 0; m_j <= 1'b0; m_k <= 1'b0; m_exp <= 1'b0;
      m_bits <= 0; m_errs <= 0; m_flag <= 1'b0; m_valid <= 1'b1;
    end else begin
      e = err_clr ? 0 : m_errs;
      f = err_clr ? 1'b0 : m_flag;
      if (m_left == 1 && q_fb !== m_exp) begin
        e = (e < MAXE) ? e + 1 : e;
        f = 1'b1;
      end
      m_errs <= e;
      m_flag <= f;
      if (m_left == 0 && tgt_valid) begin
        {m_j, m_k} <= exc(q_fb, tgt_bit);
        m_exp  <= tgt_bit;
        m_bits <= (m_bits + 1) % (MAXE + 1);
        m_left <= 2;
      end else begin
        m_j <= 1'b0;
        m_k <= 1'b0;
        if (m_left > 0) m_left <= m_left - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_J", 32'(J), 32'(m_j));
      chk("m_K", 32'(K), 32'(m_k));
      chk("m_exp_q", 32'(exp_q), 32'(m_exp));
      chk("m_busy", 32'(busy), 32'(m_left != 0));
      chk("m_tgt_ready", 32'(tgt_ready), 32'(m_left == 0));
      chk("m_bit_cnt", 32'(bit_cnt), 32'(m_bits));
      chk("m_err_cnt", 32'(err_cnt), 32'(m_errs));
      chk("m_err_flag", 32'(err_flag), 32'(m_flag));
    end
  end

  task automatic wait_rdy(input bit sat);
    int n = 0;
    while (!(sat ? s_ready : tgt_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 expected 1 at %0t", $time);
    end
  endtask

  // Called at a negedge; returns at the negedge inside CHECK
  task automatic send_bit(input logic b, input bit jk_on, input logic [1:0] jk_exp, input bit q_on);
    wait_rdy(1'b0);
    tgt_bit   = b;
    tgt_valid = 1'b1;
    @(negedge clk);
    if (jk_on) chk("drive_jk", 32'({J, K}), 32'(jk_exp));
    @(negedge clk);
    if (q_on) chk("flop_q", 32'(flop_q), 32'(b));
  endtask

  logic       seq_bits[5];
  logic [1:0] jk_tab[5];
  logic [1:0] sat_bits[5];
  logic [1:0] sat_errs[5];

  initial begin
    seq_bits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef JK_SEQ_TOGGLE_EN
    jk_tab = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11};
`else
    jk_tab = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`endif
    sat_bits = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sat_errs = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_J", 32'(J), 0);
    chk("rst_K", 32'(K), 0);
    chk("rst_ready", 32'(tgt_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bit_cnt", 32'(bit_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_err_flag", 32'(err_flag), 0);

    for (int i = 0; i < 5; i++) send_bit(seq_bits[i], 1'b1, jk_tab[i], 1'b1);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("seq_bit_cnt", 32'(bit_cnt), 5);
    chk("seq_err_cnt", 32'(err_cnt), 0);

    stuck = 1'b1;
    send_bit(1'b1, 1'b0, 2'b00, 1'b0);
    send_bit(1'b0, 1'b0, 2'b00, 1'b0);
    send_bit(1'b1, 1'b0, 2'b00, 1'b0);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("stuck_err_cnt", 32'(err_cnt), 2);
    chk("stuck_err_flag", 32'(err_flag), 1);

    send_bit(1'b1, 1'b0, 2'b00, 1'b0);
    err_clr   = 1'b1;
    tgt_valid = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_hit_err_cnt", 32'(err_cnt), 1);
    chk("clr_hit_err_flag", 32'(err_flag), 1);

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 0);
    chk("clr_err_flag", 32'(err_flag), 0);
    chk("clr_bit_cnt", 32'(bit_cnt), 9);
    stuck = 1'b0;

    wait_rdy(1'b0);
    tgt_bit   = 1'b1;
    tgt_valid = 1'b1;
    @(negedge clk);
    rst       = 1'b1;
    tgt_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_J", 32'(J), 0);
    chk("mid_rst_K", 32'(K), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_bit_cnt", 32'(bit_cnt), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    send_bit(1'b1, 1'b1, jk_tab[0], 1'b1);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_bit_cnt", 32'(bit_cnt), 1);
    chk("post_rst_err_cnt", 32'(err_cnt), 0);

    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rdy(1'b1);
      @(negedge clk);
      if (i == 4) s_valid = 1'b0;
      chk("sat_bit_cnt", 32'(s_bits), 32'(sat_bits[i]));
      repeat (2) @(negedge clk);
      chk("sat_err_cnt", 32'(s_errs), 32'(sat_errs[i]));
    end
    chk("sat_err_flag", 32'(s_flag), 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
